// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared constants, entry type and packing helper for the UART receive FIFO
package uart_rx_fifo_pkg;

    localparam int RX_ENTRY_W      = 9;
    localparam int PAR_BIT         = 8;
    localparam int DATA_MSB        = 7;
    localparam int DATA_LSB        = 0;
    localparam int DEF_DEPTH_LOG2  = 4;
    localparam int DEF_AFULL_LEVEL = 12;

    typedef logic [RX_ENTRY_W-1:0] rx_entry_t;

    function automatic rx_entry_t pack_entry(input logic par, input logic [7:0] data);
        rx_entry_t e;
        e                     = '0;
        e[PAR_BIT]            = par;
        e[DATA_MSB:DATA_LSB]  = data;
        return e;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver/APB side signal bundle of the receive FIFO
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
);
    logic                  fifo_write;
    logic [7:0]            rx_byte;
    logic                  parity_err_in;
    logic                  read_rx_byte;
    logic [7:0]            rx_data;
    logic                  rx_parity_err;
    logic                  receive_full;
    logic                  rx_empty;
    logic                  rx_full;
    logic                  rx_afull;
    logic [DEPTH_LOG2:0]   rx_count;
    logic                  overflow;

    modport master (
        output fifo_write, rx_byte, parity_err_in, read_rx_byte,
        input  rx_data, rx_parity_err, receive_full, rx_empty,
               rx_full, rx_afull, rx_count, overflow
    );

    modport slave (
        input  fifo_write, rx_byte, parity_err_in, read_rx_byte,
        output rx_data, rx_parity_err, receive_full, rx_empty,
               rx_full, rx_afull, rx_count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo_ram.sv
// rtl/uart_rx_fifo_ram.sv - entry storage, synchronous write and asynchronous read, no reset
module uart_rx_fifo_ram
    import uart_rx_fifo_pkg::*;
#(
    parameter int AW = DEF_DEPTH_LOG2
) (
    input  logic       clk,
    input  logic       i_we,
    input  logic [AW-1:0] i_waddr,
    input  rx_entry_t  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output rx_entry_t  o_rdata
);
    rx_entry_t r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO with occupancy flags and sticky overflow
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int AFULL_LEVEL = DEF_AFULL_LEVEL
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);
    localparam logic [DEPTH_LOG2:0] CNT_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_AFULL = (DEPTH_LOG2+1)'(AFULL_LEVEL);

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;

    logic      w_wr;
    logic      w_rd;
    logic      w_empty;
    logic      w_full;
    logic      w_rd_ok;
    logic      w_wr_ok;
    logic      w_drop;
    rx_entry_t w_wdata;
    rx_entry_t w_rdata;

    assign w_wr    = ~bus.fifo_write;
    assign w_rd    = bus.read_rx_byte;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_DEPTH);
    assign w_rd_ok = w_rd & ~w_empty;
    // A read of a full FIFO frees the slot the same cycle, so the write is kept.
    assign w_wr_ok = w_wr & (~w_full | w_rd_ok);
    assign w_drop  = w_wr & w_full & ~w_rd_ok;
    assign w_wdata = pack_entry(bus.parity_err_in, bus.rx_byte);

    uart_rx_fifo_ram #(
        .AW(DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Set has priority over the clear-on-read.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_rd) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.rx_data       = w_empty ? 8'h00 : w_rdata[DATA_MSB:DATA_LSB];
    assign bus.rx_parity_err = w_empty ? 1'b0  : w_rdata[PAR_BIT];
    assign bus.rx_empty      = w_empty;
    assign bus.receive_full  = ~w_empty;
    assign bus.rx_full       = w_full;
    assign bus.rx_afull      = (r_count >= CNT_AFULL);
    assign bus.rx_count      = r_count;
    assign bus.overflow      = r_overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic clk;
    logic reset;

    uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    uart_rx_fifo #(
        .DEPTH_LOG2  (4),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] sb[$];
    logic       m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        logic [8:0] head;
        head = (sb.size() > 0) ? sb[0] : 9'h000;
        chk({tag, " count"},  32'(bus.rx_count),      32'(sb.size()));
        chk({tag, " empty"},  32'(bus.rx_empty),      32'(sb.size() == 0));
        chk({tag, " avail"},  32'(bus.receive_full),  32'(sb.size() != 0));
        chk({tag, " full"},   32'(bus.rx_full),       32'(sb.size() == DEPTH));
        chk({tag, " afull"},  32'(bus.rx_afull),      32'(sb.size() >= AFULL));
        chk({tag, " ovf"},    32'(bus.overflow),      32'(m_ovf));
        chk({tag, " data"},   32'(bus.rx_data),       32'(head[7:0]));
        chk({tag, " par"},    32'(bus.rx_parity_err), 32'(head[8]));
    endtask

    task automatic cycle(input string tag, input bit wr, input logic [7:0] b, input bit p, input bit rd);
        bit         rd_ok, wr_ok, drop, full;
        logic [8:0] head;
        @(negedge clk);
        bus.fifo_write    = ~wr;
        bus.rx_byte       = b;
        bus.parity_err_in = p;
        bus.read_rx_byte  = rd;
        #1;
        if (rd && sb.size() > 0) begin
            head = sb[0];
            chk({tag, " rd data"}, 32'(bus.rx_data),       32'(head[7:0]));
            chk({tag, " rd par"},  32'(bus.rx_parity_err), 32'(head[8]));
        end
        full  = (sb.size() == DEPTH);
        rd_ok = rd && (sb.size() > 0);
        wr_ok = wr && (!full || rd_ok);
        drop  = wr && full && !rd_ok;
        if (rd_ok) void'(sb.pop_front());
        if (wr_ok) sb.push_back({p, b});
        if (drop)    m_ovf = 1'b1;
        else if (rd) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        bus.fifo_write   = 1'b1;
        bus.read_rx_byte = 1'b0;
        chk_state(tag);
    endtask

    initial begin
        reset             = 1'b1;
        bus.fifo_write    = 1'b1;
        bus.rx_byte       = 8'h00;
        bus.parity_err_in = 1'b0;
        bus.read_rx_byte  = 1'b0;
        #12;
        chk_state("reset");
        @(negedge clk);
        reset = 1'b0;

        cycle("ord w11", 1, 8'h11, 0, 0);
        cycle("ord w22", 1, 8'h22, 1, 0);
        cycle("ord w33", 1, 8'h33, 0, 0);
        for (int i = 0; i < 3; i++) cycle("ord rd", 0, 8'h00, 0, 1);

        for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 8'(i), i[0], 0);
        cycle("drop ff", 1, 8'hFF, 1, 0);
        cycle("ovf idle", 0, 8'h00, 0, 0);
        cycle("full rw ab", 1, 8'hAB, 0, 1);
        for (int i = 0; i < DEPTH; i++) cycle("drain", 0, 8'h00, 0, 1);
        cycle("rd empty", 0, 8'h00, 0, 1);

        for (int i = 0; i < DEPTH; i++) cycle("fill2", 1, 8'(8'h80 + i), 0, 0);
        cycle("drop2", 1, 8'hEE, 0, 0);
        cycle("ovf clr rd", 0, 8'h00, 0, 1);
        for (int i = 0; i < DEPTH - 1; i++) cycle("drain2", 0, 8'h00, 0, 1);

        cycle("empty rw 5c", 1, 8'h5C, 0, 1);
        cycle("rd 5c", 0, 8'h00, 0, 1);

        for (int i = 0; i < 5; i++) cycle("pre rst", 1, 8'(8'h60 + i), 1, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        m_ovf = 1'b0;
        chk_state("mid reset");
        @(negedge clk);
        reset = 1'b0;
        cycle("post rst a5", 1, 8'hA5, 0, 0);
        cycle("post rst rd", 0, 8'h00, 0, 1);

        for (int i = 0; i < 40; i++) begin
            cycle("wrap", 1, 8'(8'h40 + i), i[0], sb.size() >= 2);
            if (sb.size() < 1 || sb.size() > 3) begin
                chk("wrap occupancy", 32'(sb.size() >= 1 && sb.size() <= 3), 32'd1);
            end
        end
        while (sb.size() > 0) cycle("wrap drain", 0, 8'h00, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
